// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall scheduler for the 5-stage Tessia pipeline.
// Produces Execute operand forwarding selects, stage stall/flush enables,
// a data-memory wait-state FSM with timeout, and saturating event counters.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Ra1D,
    input  logic [REG_ADDR_W-1:0] Ra2D,
    input  logic [REG_ADDR_W-1:0] Ra1E,
    input  logic [REG_ADDR_W-1:0] Ra2E,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [REG_ADDR_W-1:0] WA3W,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  PCWrPendingF,
    input  logic                  BranchTakenE,
    input  logic                  PCSrcW,
    input  logic                  MemReqM,
    input  logic                  MemAckM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MemTimeout,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    // R15 is the PC; it is never forwarded.
    localparam logic [REG_ADDR_W-1:0] PC_REG    = REG_ADDR_W'(15);
    localparam logic [WCNT_W-1:0]     WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } mem_state_t;

    mem_state_t          state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                mem_stall;
    logic                ldr_stall;

    // RegWriteE belongs to the stage interface but no hazard term depends on it.
    logic                unused_regwrite_e;
    assign unused_regwrite_e = RegWriteE;

    // Memory-stage result wins over Writeback since it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] ra);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != PC_REG) begin
            if (RegWriteM && (WA3M == ra)) begin
                sel = FWD_MEM;
            end else if (RegWriteW && (WA3W == ra)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // Execute-stage operand forwarding selects.
    always_comb begin
        ForwardAE = fwd_sel(Ra1E);
        ForwardBE = fwd_sel(Ra2E);
    end

    // Load-use hazard: Decode reads the register a load in Execute will write.
    always_comb begin
        ldr_stall = MemtoRegE && ((WA3E == Ra1D) || (WA3E == Ra2D));
    end

    // Memory wait-state FSM next state and the stall it imposes this cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        mem_stall  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReqM && !MemAckM) begin
                    mem_stall  = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (MemAckM) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall/flush enables; a memory stall freezes everything and suppresses flushes.
    always_comb begin
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end else begin
            StallF = ldr_stall | PCWrPendingF;
            StallD = ldr_stall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
            FlushE = ldr_stall | BranchTakenE;
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, timeout flag and counters; asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed vectors push
// their hand-computed expectations; a monitor compares on every falling edge.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       PCWrPendingF, BranchTakenE, PCSrcW, MemReqM, MemAckM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [3:0] StallCount, FlushCount;

    pipeline_hazard_controller #(
        .REG_ADDR_W (4),
        .CNT_W      (4),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Ra1D        (Ra1D),
        .Ra2D        (Ra2D),
        .Ra1E        (Ra1E),
        .Ra2E        (Ra2E),
        .WA3E        (WA3E),
        .WA3M        (WA3M),
        .WA3W        (WA3W),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .PCWrPendingF(PCWrPendingF),
        .BranchTakenE(BranchTakenE),
        .PCSrcW      (PCSrcW),
        .MemReqM     (MemReqM),
        .MemAckM     (MemAckM),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .MemTimeout  (MemTimeout),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, m2r, pcwp, bt, pcsrcw, mreq, mack;
    } vin_t;

    typedef struct {
        string      name;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic       fd, fe, to;
        logic [3:0] sc, fc;
    } exp_t;

    localparam vin_t V0 = '0;

    exp_t        sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [3:0]  m_sc = '0;
    logic [3:0]  m_fc = '0;

    function automatic vin_t fv(input logic rwm, input logic [3:0] wa3m,
                                input logic rww, input logic [3:0] wa3w,
                                input logic [3:0] ra1e, input logic [3:0] ra2e);
        vin_t v;
        v = V0;
        v.rwm = rwm; v.wa3m = wa3m; v.rww = rww; v.wa3w = wa3w;
        v.ra1e = ra1e; v.ra2e = ra2e;
        return v;
    endfunction

    function automatic vin_t cv(input logic m2r, input logic [3:0] wa3e,
                                input logic [3:0] ra1d, input logic [3:0] ra2d,
                                input logic pcwp, input logic bt, input logic pcsrcw,
                                input logic mreq, input logic mack);
        vin_t v;
        v = V0;
        v.m2r = m2r; v.wa3e = wa3e; v.ra1d = ra1d; v.ra2d = ra2d;
        v.pcwp = pcwp; v.bt = bt; v.pcsrcw = pcsrcw; v.mreq = mreq; v.mack = mack;
        v.rwe = m2r;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input string name, input logic rst, input vin_t v,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] st, input logic fd, input logic fe,
                        input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        Ra1D = v.ra1d; Ra2D = v.ra2d; Ra1E = v.ra1e; Ra2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
        MemtoRegE = v.m2r; PCWrPendingF = v.pcwp; BranchTakenE = v.bt;
        PCSrcW = v.pcsrcw; MemReqM = v.mreq; MemAckM = v.mack;
        if (!rst) begin
            m_sc = '0;
            m_fc = '0;
        end
        e.name = name; e.fa = fa; e.fb = fb; e.st = st;
        e.fd = fd; e.fe = fe; e.to = to; e.sc = m_sc; e.fc = m_fc;
        sbq.push_back(e);
        if (rst) begin
            if (st[3] && (m_sc != 4'hF)) m_sc = m_sc + 4'd1;
            if ((fd || fe) && (m_fc != 4'hF)) m_fc = m_fc + 4'd1;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t e;
                logic [3:0] st;
                e  = sbq.pop_front();
                st = {StallF, StallD, StallE, StallM};
                n_tests++;
                if (ForwardAE !== e.fa || ForwardBE !== e.fb || st !== e.st ||
                    FlushD !== e.fd || FlushE !== e.fe || MemTimeout !== e.to ||
                    StallCount !== e.sc || FlushCount !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s: got fa=%b fb=%b st=%b fd=%b fe=%b to=%b sc=%0d fc=%0d; want fa=%b fb=%b st=%b fd=%b fe=%b to=%b sc=%0d fc=%0d",
                             e.name, ForwardAE, ForwardBE, st, FlushD, FlushE, MemTimeout,
                             StallCount, FlushCount, e.fa, e.fb, e.st, e.fd, e.fe, e.to,
                             e.sc, e.fc);
                end
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCWrPendingF, BranchTakenE, PCSrcW, MemReqM, MemAckM} = '0;

        // Reset state, and combinational outputs following inputs during reset.
        step("rst_idle", 1'b0, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("rst_comb", 1'b0, cv(0, 0, 0, 0, 0, 1, 0, 0, 0), 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0);
        step("rst_rel",  1'b1, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Forwarding.
        step("fwd_m_w",     1'b1, fv(1, 3, 1, 4, 3, 4),    2'b10, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fwd_prio",    1'b1, fv(1, 3, 1, 3, 3, 3),    2'b10, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fwd_w_only",  1'b1, fv(0, 3, 1, 3, 3, 3),    2'b01, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fwd_pc",      1'b1, fv(1, 15, 1, 15, 15, 15), 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fwd_nomatch", 1'b1, fv(1, 3, 1, 4, 5, 6),    2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fwd_nowrite", 1'b1, fv(0, 3, 0, 3, 3, 3),    2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Load-use.
        step("ldr_ra2",  1'b1, cv(1, 5, 0, 5, 0, 0, 0, 0, 0), 2'b00, 2'b00, 4'b1100, 1'b0, 1'b1, 1'b0);
        step("ldr_after", 1'b1, V0,                          2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("ldr_ra1",  1'b1, cv(1, 5, 5, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 4'b1100, 1'b0, 1'b1, 1'b0);
        step("ldr_noload", 1'b1, cv(0, 5, 5, 5, 0, 0, 0, 0, 0), 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("ldr_miss", 1'b1, cv(1, 5, 6, 7, 0, 0, 0, 0, 0), 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Taken branch and PC-write hazards.
        step("br_pcw_1", 1'b1, cv(0, 0, 0, 0, 1, 1, 0, 0, 0), 2'b00, 2'b00, 4'b1000, 1'b1, 1'b1, 1'b0);
        step("br_pcw_2", 1'b1, cv(0, 0, 0, 0, 1, 1, 0, 0, 0), 2'b00, 2'b00, 4'b1000, 1'b1, 1'b1, 1'b0);
        step("pcw_only", 1'b1, cv(0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0);
        step("pcsrcw",   1'b1, cv(0, 0, 0, 0, 0, 0, 1, 0, 0), 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
        step("br_only",  1'b1, cv(0, 0, 0, 0, 0, 1, 0, 0, 0), 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0);
        step("br_after", 1'b1, V0,                            2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Memory wait: three stall cycles override load-use, PC-write and branch.
        for (int i = 0; i < 3; i++) begin
            step("mem_wait", 1'b1, cv(1, 5, 0, 5, 1, 1, 0, 1, 0), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0);
        end
        step("mem_ack",   1'b1, cv(1, 5, 0, 5, 1, 1, 0, 1, 1), 2'b00, 2'b00, 4'b1100, 1'b1, 1'b1, 1'b0);
        step("mem_idle",  1'b1, V0,                            2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("mem_ack0",  1'b1, cv(0, 0, 0, 0, 0, 0, 0, 1, 1), 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("mem_idle2", 1'b1, V0,                            2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Timeout: 16 stalled cycles, then the sticky error.
        for (int i = 0; i < 16; i++) begin
            step("to_wait", 1'b1, cv(0, 0, 0, 0, 0, 0, 0, 1, 0), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0);
        end
        step("to_err",  1'b1, cv(0, 0, 0, 0, 0, 0, 0, 1, 0), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1);
        step("to_ack1", 1'b1, cv(0, 0, 0, 0, 0, 1, 0, 1, 1), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1);
        step("to_ack2", 1'b1, cv(0, 0, 0, 0, 0, 1, 0, 0, 1), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1);
        // Reset asserted between edges; the falling-edge check sees it cleared.
        step("to_areset", 1'b0, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("to_rst_req", 1'b0, cv(0, 0, 0, 0, 0, 0, 0, 1, 0), 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0);
        step("to_rel",    1'b1, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Saturation: StallF and FlushD held for 20 cycles on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, cv(0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0);
        end
        step("sat_hold", 1'b1, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("sat_hold2", 1'b1, V0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
